// File: rtl/store_unit.sv
// Store unit: SB/SH via read-modify-write, SW as a direct word write, and rejection of invalid width codes.
// Optional macro STORE_MISALIGN_TRAP_EN rejects misaligned SH/SW instead of aligning them down.
module store_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_data,
  input  logic [2:0]   req_funct3,
  output logic [N-1:0] mem_addr,
  output logic         mem_wr_ena,
  output logic [N-1:0] mem_din,
  input  logic [N-1:0] mem_dout,
  output logic         done,
  output logic         err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [N-1:0] addr_q;
  logic [N-1:0] data_q;
  logic [2:0]   f3_q;
  logic         accept;
  logic         f3_ok;
  logic         misalign;
  logic [N-1:0] addr_sel;
  logic [N-1:0] merged;

  assign accept = (state == IDLE) && req_valid;
  assign f3_ok  = (req_funct3 == F3_SB) || (req_funct3 == F3_SH) || (req_funct3 == F3_SW);

`ifdef STORE_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3 == F3_SH) && req_addr[0]) ||
                    ((req_funct3 == F3_SW) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!f3_ok || misalign)
            state_nxt = ERR;
          else if (req_funct3 == F3_SW)
            state_nxt = WR;
          else
            state_nxt = RD;
        end
      end
      RD:      state_nxt = WR;
      WR:      state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      f3_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= req_addr;
        data_q <= req_data;
        f3_q   <= req_funct3;
      end
    end
  end

  // Memory sees the request address while idle so the RMW read can be issued from RD.
  assign addr_sel   = (state == IDLE) ? req_addr : addr_q;
  assign mem_addr   = {2'b00, addr_sel[N-1:2]};
  assign req_ready  = (state == IDLE);
  assign mem_wr_ena = (state == WR);
  assign done       = (state == WR) || (state == ERR);
  assign err        = (state == ERR);

  // mem_dout in WR is the old word fetched from the address presented during RD.
  always_comb begin
    merged = mem_dout;
    case (f3_q)
      F3_SB:   merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
      F3_SH:   merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
      default: merged = data_q;
    endcase
  end

  always_comb begin
    mem_din = '0;
    if (state == WR)
      mem_din = merged;
  end

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: directed cases plus random stores checked against a byte-lane memory model.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rstb;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [2:0]  req_funct3;
  logic [31:0] mem_addr;
  logic        mem_wr_ena;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        done;
  logic        err;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] last_din;
  logic        misalign_trap;

  always #5 clk = ~clk;

  store_unit #(.N(32)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_funct3 (req_funct3),
    .mem_addr   (mem_addr),
    .mem_wr_ena (mem_wr_ena),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .done       (done),
    .err        (err)
  );

  // Synchronous-read memory standing in for port 0.
  always @(posedge clk) begin
    if (mem_wr_ena)
      mem[mem_addr[3:0]] <= mem_din;
    mem_dout <= mem[mem_addr[3:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    logic        exp_err;
    int          lat;
    int          cyc;
    int          sh;
    logic [31:0] old;
    logic [31:0] mask;
    logic [31:0] exp_new;
    exp_err = (f3 > 3'd2) ||
              (misalign_trap && (((f3 == 3'd1) && a[0]) || ((f3 == 3'd2) && (a[1:0] != 2'b00))));
    lat = (exp_err || f3 == 3'd2) ? 1 : 2;
    old = ref_mem[a[5:2]];
    exp_new = d;
    if (f3 == 3'd0) begin
      sh = 8 * int'(a[1:0]);
      mask = 32'h0000_00FF << sh;
      exp_new = (old & ~mask) | ((d & 32'h0000_00FF) << sh);
    end else if (f3 == 3'd1) begin
      sh = 16 * int'(a[1]);
      mask = 32'h0000_FFFF << sh;
      exp_new = (old & ~mask) | ((d & 32'h0000_FFFF) << sh);
    end

    @(negedge clk);
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_addr   = a;
    req_data   = d;
    req_funct3 = f3;
    #1;
    chk("idle_mem_addr", mem_addr, {2'b00, a[31:2]});
    @(posedge clk);
    #1;
    req_valid  = 1'($urandom);
    req_addr   = $urandom;
    req_data   = $urandom;
    req_funct3 = 3'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 5) begin
      chk("busy_no_write", {31'd0, mem_wr_ena}, 32'd0);
      chk("busy_not_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      req_addr = $urandom;
      req_data = $urandom;
      cyc++;
    end
    req_valid = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("latency", cyc, lat);
    chk("err", {31'd0, err}, {31'd0, exp_err});
    chk("wr_ena", {31'd0, mem_wr_ena}, {31'd0, !exp_err});
    last_din = mem_din;
    if (!exp_err) begin
      chk("wr_addr", mem_addr, {28'd0, a[5:2]});
      chk("wr_din", mem_din, exp_new);
      ref_mem[a[5:2]] = exp_new;
    end else begin
      chk("err_din_zero", mem_din, 32'd0);
    end
    @(posedge clk);
    #1;
    chk("post_done_low", {31'd0, done}, 32'd0);
    chk("post_ready", {31'd0, req_ready}, 32'd1);
    chk("post_din_zero", mem_din, 32'd0);
  endtask

  initial begin
`ifdef STORE_MISALIGN_TRAP_EN
    misalign_trap = 1'b1;
`else
    misalign_trap = 1'b0;
`endif
    rstb       = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h10;
    req_data   = 32'h1234_5678;
    req_funct3 = 3'd2;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;

    // A request held valid across reset edges must not be taken.
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_wr", {31'd0, mem_wr_ena}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_din", mem_din, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rstb = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_no_accept", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 16; i++) do_store(32'(i * 4), $urandom, 3'd2);

    do_store(32'h10, 32'hDEAD_BEEF, 3'd2);
    chk("sw_deadbeef", last_din, 32'hDEAD_BEEF);
    do_store(32'h10, 32'h1122_3344, 3'd2);
    do_store(32'h12, 32'h0000_00AA, 3'd0);
    chk("sb_merge", last_din, 32'h11AA_3344);
    do_store(32'h10, 32'h1122_3344, 3'd2);
    do_store(32'h12, 32'h0000_BEEF, 3'd1);
    chk("sh_merge", last_din, 32'hBEEF_3344);
    do_store(32'h14, 32'h5555_5555, 3'd3);
    do_store(32'h11, 32'hCAFE_F00D, 3'd2);
    do_store(32'h13, 32'h0000_7777, 3'd1);
    do_store(32'h17, 32'h0000_0099, 3'd0);

    // Reset during the RD phase of a byte store must suppress the write.
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = 32'h12;
    req_data   = 32'h0000_0055;
    req_funct3 = 3'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rd_busy", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rstb = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_wr", {31'd0, mem_wr_ena}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_mem_intact", mem[4], ref_mem[4]);
    do_store(32'h10, 32'h0BAD_F00D, 3'd2);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      do_store(32'($urandom_range(0, 63)), $urandom, f);
    end

    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
